// File: rtl/matrix_load_sequencer.sv
// -----------------------------------------------------------------------------
// matrix_load_sequencer
//
// Upstream feeder for the parallel matrix multiplier. A start pulse begins a
// load. The block reads square N x N matrices A and B from two synchronous
// element memories. Each pair of vertically adjacent elements is packed into a
// multiplier input word {A[r][c], A[r+1][c], B[r][c], B[r+1][c]}. Each word is
// presented with a one-cycle read_en strobe.
//
// The scan order is column-major over row pairs:
//   for c = 0..N-1, for r = 0,2,..,N-2 -> one word (N*N/2 words per load).
// Each word takes ADDR_LO -> ADDR_HI -> CAP_HI -> EMIT. The block waits in
// WAIT while sink_ready is low. A one-cycle done pulse follows the last word.
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous, active-high reset
//   start      in   begin a load (sampled only in IDLE)
//   a_addr     out  A memory read address, row-major r*N+c
//   a_data     in   A memory read data, valid one cycle after a_addr
//   b_addr     out  B memory read address, always equal to a_addr
//   b_data     in   B memory read data, valid one cycle after b_addr
//   sink_ready in   downstream can accept a word
//   rdata      out  packed word, MSB first; holds until the next capture
//   read_en    out  one-cycle strobe, rdata valid while high
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse after the last word
//   word_cnt   out  words emitted in the current load
// -----------------------------------------------------------------------------
module matrix_load_sequencer #(
    parameter int WIDTH        = 8,
    parameter int MATRIX_WIDTH = 4,
    parameter int ADDR_W       = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [ADDR_W-1:0]    a_addr,
    input  logic [WIDTH-1:0]     a_data,
    output logic [ADDR_W-1:0]    b_addr,
    input  logic [WIDTH-1:0]     b_data,
    input  logic                 sink_ready,
    output logic [4*WIDTH-1:0]   rdata,
    output logic                 read_en,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    word_cnt
);

    localparam int N  = MATRIX_WIDTH;
    // One extra bit so that c can reach N after the last word without wrapping.
    localparam int CW = $clog2(N) + 1;

    localparam logic [CW-1:0] R_LAST = CW'(N - 2);
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_LO,
        ADDR_HI,
        CAP_HI,
        WAIT,
        EMIT,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        r_q, r_d;
    logic [CW-1:0]        c_q, c_d;
    logic [WIDTH-1:0]     lo_a_q, lo_a_d;
    logic [WIDTH-1:0]     lo_b_q, lo_b_d;
    logic [4*WIDTH-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]    word_cnt_q, word_cnt_d;

    logic [CW-1:0]        row_sel;
    logic [ADDR_W-1:0]    addr;

    // ADDR_HI addresses the lower row of the pair. Every other state presents
    // r*N+c, so the memories already see the next pair's top element in IDLE.
    always_comb begin
        row_sel = r_q;
        if (state_q == ADDR_HI) begin
            row_sel = r_q + CW'(1);
        end
        addr = ADDR_W'(row_sel) * ADDR_W'(N) + ADDR_W'(c_q);
    end

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        c_d        = c_q;
        lo_a_d     = lo_a_q;
        lo_b_d     = lo_b_q;
        rdata_d    = rdata_q;
        word_cnt_d = word_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ADDR_LO;
                end
            end

            ADDR_LO: begin
                state_d = ADDR_HI;
            end

            ADDR_HI: begin
                // Data for the ADDR_LO address arrives this cycle.
                lo_a_d  = a_data;
                lo_b_d  = b_data;
                state_d = CAP_HI;
            end

            CAP_HI: begin
                // The hi elements go straight into the packed word. They
                // are needed nowhere else, so they get no separate register.
                rdata_d = {lo_a_q, a_data, lo_b_q, b_data};
                state_d = sink_ready ? EMIT : WAIT;
            end

            WAIT: begin
                if (sink_ready) begin
                    state_d = EMIT;
                end
            end

            EMIT: begin
                word_cnt_d = word_cnt_q + ADDR_W'(1);
                if (r_q == R_LAST) begin
                    r_d = '0;
                    c_d = c_q + CW'(1);
                end else begin
                    r_d = r_q + CW'(2);
                end
                if ((r_q == R_LAST) && (c_q == C_LAST)) begin
                    state_d = DONE;
                end else begin
                    state_d = ADDR_LO;
                end
            end

            DONE: begin
                r_d        = '0;
                c_d        = '0;
                word_cnt_d = '0;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            r_q        <= '0;
            c_q        <= '0;
            lo_a_q     <= '0;
            lo_b_q     <= '0;
            rdata_q    <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            c_q        <= c_d;
            lo_a_q     <= lo_a_d;
            lo_b_q     <= lo_b_d;
            rdata_q    <= rdata_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign a_addr   = addr;
    assign b_addr   = addr;
    assign rdata    = rdata_q;
    assign read_en  = (state_q == EMIT);
    assign done     = (state_q == DONE);
    assign busy     = (state_q != IDLE);
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_matrix_load_sequencer.sv
// -----------------------------------------------------------------------------
// tb_matrix_load_sequencer
//
// Directed bench for matrix_load_sequencer with default parameters (N=4).
// The element memories are preloaded with A[i][j] = 4i+j+1 and
// B[i][j] = 0x80+4i+j. The expected words and addresses are hand-computed
// constants. Cycle k of a load is the k-th falling edge after the rising edge
// that samples start.
// -----------------------------------------------------------------------------
module tb_matrix_load_sequencer;

    localparam int WIDTH  = 8;
    localparam int N      = 4;
    localparam int ADDR_W = 4;

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic [ADDR_W-1:0]    a_addr;
    logic [WIDTH-1:0]     a_data;
    logic [ADDR_W-1:0]    b_addr;
    logic [WIDTH-1:0]     b_data;
    logic                 sink_ready;
    logic [4*WIDTH-1:0]   rdata;
    logic                 read_en;
    logic                 busy;
    logic                 done;
    logic [ADDR_W-1:0]    word_cnt;

    int n_checks;
    int n_fail;

    logic [WIDTH-1:0] mem_a [16];
    logic [WIDTH-1:0] mem_b [16];

    logic [31:0] exp_word [8] = '{
        32'h01058084, 32'h090D888C, 32'h02068185, 32'h0A0E898D,
        32'h03078286, 32'h0B0F8A8E, 32'h04088387, 32'h0C108B8F
    };
    logic [3:0] exp_lo [8] = '{4'd0, 4'd8, 4'd1, 4'd9, 4'd2, 4'd10, 4'd3, 4'd11};
    logic [3:0] exp_hi [8] = '{4'd4, 4'd12, 4'd5, 4'd13, 4'd6, 4'd14, 4'd7, 4'd15};

    matrix_load_sequencer #(
        .WIDTH        (WIDTH),
        .MATRIX_WIDTH (N),
        .ADDR_W       (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .sink_ready (sink_ready),
        .rdata      (rdata),
        .read_en    (read_en),
        .busy       (busy),
        .done       (done),
        .word_cnt   (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous element memories: data valid one cycle after the address.
    always @(posedge clk) begin
        a_data <= mem_a[a_addr];
        b_data <= mem_b[b_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one load. stall_len>0 holds sink_ready low for cycles
    // [stall_from, stall_from+stall_len). restart_cyc re-pulses start in that
    // cycle. reset_cyc asserts reset in that cycle and ends the load. exact
    // enables cycle-accurate timing and address checks for an unstalled load.
    task automatic run_load(input int stall_from, input int stall_len,
                            input int restart_cyc, input int reset_cyc,
                            input bit exact, input int want_words,
                            input int want_dones);
        int cyc;
        int words;
        int dones;
        bit fin;
        int k;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_word_cnt", 32'(word_cnt), 32'd0);
        start      = 1'b1;
        sink_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        words = 0;
        dones = 0;
        fin   = 1'b0;
        while (!fin && cyc < 200) begin
            check("b_addr_eq_a_addr", 32'(b_addr), 32'(a_addr));
            check("busy", 32'(busy), 32'd1 - 32'(cyc == reset_cyc + 1));
            if (read_en) begin
                if (words < 8) begin
                    check("word", rdata, exp_word[words]);
                end else begin
                    check("extra_word", 32'(words), 32'd7);
                end
                words++;
            end
            if (done) begin
                dones++;
                check("word_cnt_at_done", 32'(word_cnt), 32'd8);
                fin = 1'b1;
            end
            if (exact) begin
                k = (cyc - 1) / 4;
                check("read_en_timing", 32'(read_en), 32'((cyc % 4 == 0) && cyc <= 32));
                check("done_timing", 32'(done), 32'(cyc == 33));
                if (cyc <= 32 && cyc % 4 == 1) check("addr_lo", 32'(a_addr), 32'(exp_lo[k]));
                if (cyc <= 32 && cyc % 4 == 2) check("addr_hi", 32'(a_addr), 32'(exp_hi[k]));
            end
            if (stall_len > 0 && cyc >= stall_from + 2 && cyc <= stall_from + stall_len) begin
                check("stall_no_read_en", 32'(read_en), 32'd0);
                check("stall_rdata_held", rdata, 32'h02068185);
            end
            if (stall_len > 0 && cyc == stall_from + stall_len + 1) begin
                check("stall_release_emit", 32'(read_en), 32'd1);
            end
            if (cyc == reset_cyc + 1) begin
                check("rst_read_en", 32'(read_en), 32'd0);
                check("rst_rdata", rdata, 32'd0);
                check("rst_word_cnt", 32'(word_cnt), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                fin = 1'b1;
            end
            start      = (cyc == restart_cyc);
            sink_ready = !(stall_len > 0 && cyc >= stall_from && cyc < stall_from + stall_len);
            reset      = (cyc == reset_cyc);
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("load_finished", 32'(fin), 32'd1);
        check("word_count", 32'(words), 32'(want_words));
        check("done_count", 32'(dones), 32'(want_dones));
        start      = 1'b0;
        reset      = 1'b0;
        sink_ready = 1'b1;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        start      = 1'b0;
        sink_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                mem_a[i*4+j] = 8'(4*i + j + 1);
                mem_b[i*4+j] = 8'(8'h80 + 4*i + j);
            end
        end

        // Reset state; start is high during reset and must be ignored.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_read_en", 32'(read_en), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_word_cnt", 32'(word_cnt), 32'd0);
        check("reset_a_addr", 32'(a_addr), 32'd0);
        check("reset_b_addr", 32'(b_addr), 32'd0);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_idle", 32'(busy), 32'd0);

        // Plain load with exact timing, then a back-to-back load.
        run_load(0, 0, -1, -1, 1'b1, 8, 1);
        run_load(0, 0, -1, -1, 1'b1, 8, 1);

        // Backpressure around the third word.
        run_load(10, 10, -1, -1, 1'b0, 8, 1);

        // A start pulse mid-load is ignored, and the timing is unchanged.
        run_load(0, 0, 10, -1, 1'b1, 8, 1);

        // Reset in cycle 14 aborts after three words.
        run_load(0, 0, -1, 14, 1'b0, 3, 0);
        repeat (6) begin
            @(negedge clk);
            check("after_reset_quiet", 32'(read_en), 32'd0);
        end

        // A fresh load after the abort starts again from the first word.
        run_load(0, 0, -1, -1, 1'b1, 8, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
